// File: rtl/std_delay_credit_ctrl.sv
// std_delay_credit_ctrl: credit-based valid/ready wrapper around a non-stallable fixed-latency datapath,
// admitting words only when the output FIFO is guaranteed to have room for their return.
module std_delay_credit_ctrl #(
  parameter int  DELAY = 1,
  parameter int  WIDTH = 8,
  parameter type TYPE  = logic [WIDTH-1:0],
  parameter int  DEPTH = 4,
  parameter int  CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clear,
  input  logic          i_valid,
  output logic          o_ready,
  input  TYPE           i_d,
  output logic          o_dp_valid,
  output TYPE           o_dp_d,
  input  TYPE           i_dp_d,
  output logic          o_valid,
  input  logic          i_ready,
  output TYPE           o_d,
  output logic [CW-1:0] o_credits,
  output logic          o_busy
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  if (DELAY < 1) begin : g_bad_delay
    $error("std_delay_credit_ctrl: DELAY must be >= 1");
  end
  if (DEPTH < 1) begin : g_bad_depth
    $error("std_delay_credit_ctrl: DEPTH must be >= 1");
  end
  logic [DELAY-1:0] vld;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, credits;
  TYPE              mem [DEPTH];
  logic             accept, pop, ret, push;
  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
  endfunction
  // i_rst gates the handshakes so nothing is offered while the async reset is held
  always_comb begin
    o_ready    = i_rst & (credits != '0) & !i_clear;
    o_valid    = i_rst & (count != '0) & !i_clear;
    accept     = i_valid & o_ready;
    pop        = o_valid & i_ready;
    ret        = vld[DELAY-1];
    push       = ret & !i_clear;
    o_dp_valid = accept;
    o_dp_d     = i_d;
    o_d        = mem[rd_ptr];
    o_credits  = credits;
    o_busy     = (count != '0) | (|vld);
  end
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      vld     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      credits <= CW'(DEPTH);
    end else if (i_clear) begin
      vld     <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      credits <= CW'(DEPTH);
    end else begin
      vld     <= DELAY'({vld, accept});
      wr_ptr  <= push ? nxt(wr_ptr) : wr_ptr;
      rd_ptr  <= pop ? nxt(rd_ptr) : rd_ptr;
      count   <= count + CW'(push) - CW'(pop);
      credits <= credits - CW'(accept) + CW'(pop);
    end
  end
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_dp_d;
  end
  // a return into a full FIFO means the credit accounting is broken
  assert property (@(posedge i_clk) disable iff (!i_rst) !(ret && count == CW'(DEPTH)))
    else $error("std_delay_credit_ctrl: datapath return while FIFO full");
endmodule

// File: tb/tb_std_delay_credit_ctrl.sv
// tb_std_delay_credit_ctrl: random and directed traffic against a queue-based model of the credit controller.
module tb_std_delay_credit_ctrl;
  localparam int DELAY = 3;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  logic             i_clk = 0, i_rst = 0, i_clear = 0, i_valid = 0, i_ready = 0;
  logic [WIDTH-1:0] i_d = '0, i_dp_d, o_dp_d, o_d;
  logic             o_ready, o_dp_valid, o_valid, o_busy;
  logic [CW-1:0]    o_credits;
  int n_chk = 0, n_pass = 0, cyc = 0;
  logic [WIDTH-1:0] fq[$], iq_d[$];
  int               iq_t[$];
  logic [WIDTH-1:0] dp [DELAY];
  std_delay_credit_ctrl #(.DELAY(DELAY), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_clear(i_clear), .i_valid(i_valid), .o_ready(o_ready),
    .i_d(i_d), .o_dp_valid(o_dp_valid), .o_dp_d(o_dp_d), .i_dp_d(i_dp_d), .o_valid(o_valid),
    .i_ready(i_ready), .o_d(o_d), .o_credits(o_credits), .o_busy(o_busy)
  );
  always #5 i_clk = ~i_clk;
  // stand-in datapath: exact DELAY-cycle pipe, junk data on idle slots
  always @(posedge i_clk) begin
    dp[0] <= o_dp_valid ? o_dp_d : WIDTH'($urandom);
    for (int k = 1; k < DELAY; k++) dp[k] <= dp[k-1];
  end
  assign i_dp_d = dp[DELAY-1];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask
  function automatic int m_credits();
    return DEPTH - fq.size() - iq_d.size();
  endfunction
  task automatic flush();
    fq.delete();
    iq_d.delete();
    iq_t.delete();
  endtask
  // one clock: compare at negedge, then advance the model across the posedge
  task automatic step();
    bit er, ev;
    @(negedge i_clk);
    er = i_rst && !i_clear && m_credits() != 0;
    ev = i_rst && !i_clear && fq.size() != 0;
    chk("ready", o_ready, er);
    chk("valid", o_valid, ev);
    chk("dp_valid", o_dp_valid, er && i_valid);
    if (er && i_valid) chk("dp_d", o_dp_d, i_d);
    if (ev) chk("o_d", o_d, fq[0]);
    chk("credits", o_credits, m_credits());
    chk("busy", o_busy, fq.size() != 0 || iq_d.size() != 0);
    @(posedge i_clk);
    if (!i_rst || i_clear) flush();
    else begin
      if (ev && i_ready) void'(fq.pop_front());
      if (iq_t.size() != 0 && iq_t[0] + DELAY == cyc) begin
        fq.push_back(iq_d.pop_front());
        void'(iq_t.pop_front());
      end
      if (er && i_valid) begin
        iq_d.push_back(i_d);
        iq_t.push_back(cyc);
      end
    end
    cyc++;
    #1;
  endtask
  task automatic send(input logic [WIDTH-1:0] d);
    i_valid = 1;
    i_d = d;
    step();
    i_valid = 0;
  endtask
  initial begin
    int lat, d, guard;
    bit a;
    repeat (2) step();
    i_rst = 1;
    step();
    i_ready = 1;
    send(8'h11);
    lat = 1;
    while (!o_valid && lat < 12) begin
      step();
      lat++;
    end
    chk("latency", lat, DELAY + 1);
    chk("lat_data", o_d, 8'h11);
    repeat (3) step();
    d = 1;
    guard = 0;
    while (d <= 10 && guard < 100) begin
      i_valid = 1;
      i_d = WIDTH'(d);
      a = o_ready;
      step();
      if (a) d++;
      guard++;
    end
    chk("stream_done", d, 11);
    i_valid = 0;
    repeat (8) step();
    i_ready = 0;
    for (int k = 0; k < 6; k++) send(WIDTH'(8'h40 + k));
    repeat (4) step();
    chk("full_credits", o_credits, 0);
    chk("full_ready", o_ready, 0);
    i_ready = 1;
    repeat (8) step();
    i_ready = 0;
    send(8'hA1);
    repeat (3) step();
    send(8'hA2);
    send(8'hA3);
    i_clear = 1;
    step();
    i_clear = 0;
    chk("clr_valid", o_valid, 0);
    chk("clr_credits", o_credits, DEPTH);
    chk("clr_busy", o_busy, 0);
    i_ready = 1;
    repeat (6) step();
    for (int k = 0; k < 500; k++) begin
      i_valid = $urandom_range(0, 3) != 0;
      i_ready = $urandom_range(0, 2) != 0;
      i_clear = $urandom_range(0, 40) == 0;
      i_d = WIDTH'($urandom);
      if (k == 250) begin
        i_clear = 0;
        i_ready = 0;
        repeat (6) send(WIDTH'($urandom));
        i_valid = 1;
        #1 i_rst = 0;
        #1;
        chk("arst_valid", o_valid, 0);
        chk("arst_dp_valid", o_dp_valid, 0);
        chk("arst_ready", o_ready, 0);
        chk("arst_credits", o_credits, DEPTH);
        chk("arst_busy", o_busy, 0);
        flush();
        step();
        i_rst = 1;
        i_valid = 0;
        i_ready = 1;
        send(8'h5A);
        lat = 1;
        while (!o_valid && lat < 12) begin
          step();
          lat++;
        end
        chk("arst_latency", lat, DELAY + 1);
        chk("arst_data", o_d, 8'h5A);
      end
      step();
    end
    i_valid = 0;
    i_clear = 0;
    i_ready = 1;
    repeat (10) step();
    chk("end_credits", o_credits, DEPTH);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
